// File: rtl/dtc_pkg.sv
// Shared types for the decision-tree majority-vote stage.
package dtc_pkg;

  localparam int unsigned N_CLASS = 4;
  localparam int unsigned CLASS_W = 2;

  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    ARGMAX = 2'd1,
    HOLD   = 2'd2
  } vote_state_t;

endpackage

// File: rtl/dtc_vote_counter.sv
// Per-class vote counter with synchronous clear; saturates at WINDOW.
module dtc_vote_counter #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_W'(WINDOW))) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dtc_vote_window.sv
// Windowed majority vote over classifier predictions: accumulate, sequential argmax, hold result.
module dtc_vote_window
  import dtc_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_class,
  output logic [CNT_W-1:0] out_count,
  output logic             out_tie,
  output logic [CNT_W-1:0] out_samples
);

  vote_state_t      state_q, state_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] best_q, best_d;
  class_t           best_idx_q, best_idx_d;
  logic             tie_q, tie_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  class_t           out_class_q, out_class_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_tie_q, out_tie_d;
  logic [CNT_W-1:0] out_samples_q, out_samples_d;

  logic             accept;
  logic             done;
  logic [CNT_W-1:0] samples_nxt;
  logic [CNT_W-1:0] cur_vote;
  logic [CNT_W-1:0] votes [N_CLASS];

  assign accept      = in_valid & in_ready_q;
  assign done        = out_valid_q & out_ready;
  assign samples_nxt = samples_q + CNT_W'(accept);
  assign cur_vote    = votes[idx_q];

  for (genvar g = 0; g < N_CLASS; g++) begin : g_vote
    dtc_vote_counter #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept && (in_class == class_t'(g))),
      .clr   (done),
      .count (votes[g])
    );
  end

  always_comb begin
    state_d       = state_q;
    samples_d     = samples_q;
    idx_d         = idx_q;
    best_d        = best_q;
    best_idx_d    = best_idx_q;
    tie_d         = tie_q;
    out_class_d   = out_class_q;
    out_count_d   = out_count_q;
    out_tie_d     = out_tie_q;
    out_samples_d = out_samples_q;

    case (state_q)
      ACCUM: begin
        samples_d = samples_nxt;
        // A coincident accept is counted before flush closes the window.
        if ((accept && (samples_nxt == CNT_W'(WINDOW))) ||
            (flush && (samples_nxt != '0))) begin
          state_d = ARGMAX;
          idx_d   = 2'd0;
        end
      end
      ARGMAX: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd0) begin
          best_d     = cur_vote;
          best_idx_d = 2'd0;
          tie_d      = 1'b0;
        end else if (cur_vote > best_q) begin
          best_d     = cur_vote;
          best_idx_d = class_t'(idx_q);
          tie_d      = 1'b0;
        end else if (cur_vote == best_q) begin
          tie_d = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d       = HOLD;
          out_class_d   = best_idx_d;
          out_count_d   = best_d;
          out_tie_d     = tie_d;
          out_samples_d = samples_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d    = ACCUM;
          samples_d  = '0;
          best_d     = '0;
          best_idx_d = '0;
          tie_d      = 1'b0;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      samples_q     <= '0;
      idx_q         <= 2'd0;
      best_q        <= '0;
      best_idx_q    <= '0;
      tie_q         <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_class_q   <= '0;
      out_count_q   <= '0;
      out_tie_q     <= 1'b0;
      out_samples_q <= '0;
    end else begin
      state_q       <= state_d;
      samples_q     <= samples_d;
      idx_q         <= idx_d;
      best_q        <= best_d;
      best_idx_q    <= best_idx_d;
      tie_q         <= tie_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_class_q   <= out_class_d;
      out_count_q   <= out_count_d;
      out_tie_q     <= out_tie_d;
      out_samples_q <= out_samples_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_class   = out_class_q;
  assign out_count   = out_count_q;
  assign out_tie     = out_tie_q;
  assign out_samples = out_samples_q;

endmodule

// File: doc/dtc_vote_window.md
# dtc_vote_window

Streaming majority-vote stage placed directly downstream of a combinational decision-tree classifier (8-bit feature vector in, 2-bit class out). It accepts one 2-bit prediction per handshake and accumulates per-class votes over a window of WINDOW samples, or fewer on flush. It then resolves the winning class with a sequential argmax and presents it on a valid/ready output. It converts noisy per-sample tree decisions into one stable decision per window.

## Interface
- WINDOW, 16: samples per decision; legal range 1..255.
- CNT_W, $clog2(WINDOW+1): derived width of vote and sample counters; not overridden.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_class carries a prediction.
- in_ready  out  1  stage accepts a prediction; high only in ACCUM.
- in_class  in  2  class from the tree (0..3).
- flush  in  1  single-cycle request to close the current window early.
- out_valid  out  1  decision available.
- out_ready  in  1  consumer takes the decision.
- out_class  out  2  winning class.
- out_count  out  CNT_W  votes received by the winner.
- out_tie  out  1  another class had equal votes.
- out_samples  out  CNT_W  samples in the closed window.

## Operation
- States: ACCUM, ARGMAX, HOLD. Reset state is ACCUM.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready, increment vote[in_class] and the sample counter.
  - When the accepted sample brings the sample counter to WINDOW, go to ARGMAX.
  - On flush with sample counter ≥1, go to ARGMAX.
  - flush with zero samples is ignored.
  - flush in the same cycle as an accept counts the sample first, then closes the window.
- ARGMAX:
  - in_ready=0.
  - Index idx steps 0..3, one class per cycle.
  - Replace the best candidate only if vote[idx] > best. Ties keep the lower index and set tie.
  - A later strictly greater vote clears tie.
  - After idx=3, load the output registers and go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - All out_* are stable until out_valid&out_ready.
  - On that handshake, clear votes, sample counter, best and tie, then return to ACCUM.
  - in_ready rises in the following cycle.
- flush is ignored in ARGMAX and HOLD.
- Widths and overflow:
  - Every counter is CNT_W bits; no counter can exceed WINDOW, so overflow is impossible.
  - out_count ≤ out_samples always holds.
- Reset:
  - rst at any time, including mid-ARGMAX or mid-HOLD, drops the pending decision and returns to ACCUM.
  - Reset values: out_valid=0, out_class=0, out_count=0, out_tie=0, out_samples=0, all votes=0, in_ready=1.

## Timing
- The accept edge of the last sample (or of flush) is E0. ARGMAX occupies E1..E4. out_valid is high after E4, giving 4-cycle latency.
- Minimum window period is WINDOW + 5 cycles with out_ready held high. Accept and output never overlap.
- in_ready and out_valid are decoded from the registered state and do not depend combinationally on in_valid or out_ready.

## Structure
- Shared package dtc_pkg:
  - class_t (logic [1:0]);
  - N_CLASS=4;
  - state enum vote_state_t {ACCUM, ARGMAX, HOLD}.
- Sub-module dtc_vote_counter: one instance per class, with inc, clr and count, saturating at WINDOW as a safety net.
- The FSM and argmax datapath stay in the top module.

## Test plan
- WINDOW=4, classes 2,2,1,3, out_ready=1 → out_class=2, out_count=2, out_tie=0, out_samples=4; out_valid rises exactly 4 cycles after the 4th accept.
- WINDOW=4, classes 1,3,3,1 → out_class=1, out_count=2, out_tie=1. Then 3,3,3,0 → out_class=3, out_count=3, out_tie=0, confirming counters were cleared.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD with in_valid=1 → out_* constant, in_ready=0, no votes change; release → in_ready=1 one cycle after the handshake.
- Flush:
  - with 0 samples → stays in ACCUM, no out_valid.
  - after classes 0,0 → out_class=0, out_count=2, out_samples=2.
  - flush coincident with a third accept of class 1 → out_samples=3.
- Reset asserted during ARGMAX → out_valid=0 and in_ready=1 immediately. The next window 2,2,2,2 yields out_class=2, out_count=4, out_samples=4 with no residue.
- WINDOW=1 with a back-to-back stream 3,0,1 and out_ready=1 → three decisions 3,0,1, each out_count=1, spaced 6 cycles apart.
